// File: rtl/clock_core_multi_alarm.sv
// 24-hour BCD time-of-day core with N minute-resolution alarms, ring/snooze/stop
// control and a 12/24-hour display view.
module clock_core_multi_alarm #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int N_ALARM    = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int IW         = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_valid,
  input  logic [23:0]   set_time,
  output logic          set_err,
  input  logic          alm_wr,
  input  logic [IW-1:0] alm_idx,
  input  logic          alm_en,
  input  logic [15:0]   alm_time,
  input  logic          snooze,
  input  logic          stop,
  input  logic          mode_12h,
  output logic [23:0]   time_bcd,
  output logic [23:0]   disp_bcd,
  output logic          pm,
  output logic          sec_tick,
  output logic          ring,
  output logic [IW-1:0] ring_idx
);

  localparam int PW        = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int RW        = $clog2(RING_SEC + 1);
  localparam int SW        = $clog2(SNZ_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;

  logic [PW-1:0] presc_q, presc_d;
  logic [23:0]   time_q, time_d;
  logic          sec_tick_q, set_err_q;
  logic          tick, tick_eff, set_ok;

  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [3:0] hs, hg, ms, mg, ss, sg;
    {hs, hg, ms, mg, ss, sg} = t;
    if (sg != 4'd9) sg = sg + 4'd1;
    else begin
      sg = 4'd0;
      if (ss != 4'd5) ss = ss + 4'd1;
      else begin
        ss = 4'd0;
        if (mg != 4'd9) mg = mg + 4'd1;
        else begin
          mg = 4'd0;
          if (ms != 4'd5) ms = ms + 4'd1;
          else begin
            ms = 4'd0;
            if (hs == 4'd2 && hg == 4'd3) begin
              hs = 4'd0;
              hg = 4'd0;
            end else if (hg == 4'd9) begin
              hg = 4'd0;
              hs = hs + 4'd1;
            end else hg = hg + 4'd1;
          end
        end
      end
    end
    return {hs, hg, ms, mg, ss, sg};
  endfunction

  assign tick     = (presc_q == PW'(CLK_FREQ - 1));
  // A set request swallows a coincident tick: no increment, no sec_tick, no alarm count.
  assign tick_eff = tick & ~set_valid;
  assign set_ok   = (set_time[11:8] <= 4'd9) && (set_time[3:0] <= 4'd9) &&
                    (set_time[15:12] <= 4'd5) && (set_time[7:4] <= 4'd5) &&
                    ((set_time[23:20] < 4'd2 && set_time[19:16] <= 4'd9) ||
                     (set_time[23:20] == 4'd2 && set_time[19:16] <= 4'd3));

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    time_d  = time_q;
    if (set_valid) begin
      if (set_ok) begin
        time_d  = set_time;
        presc_d = '0;
      end
    end else if (tick) begin
      time_d = bcd_inc(time_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      time_q     <= '0;
      sec_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      time_q     <= time_d;
      sec_tick_q <= tick_eff;
      set_err_q  <= set_valid & ~set_ok;
    end
  end

  logic        alm_en_q   [N_ALARM];
  logic [15:0] alm_time_q [N_ALARM];

  genvar gi;
  generate
    for (gi = 0; gi < N_ALARM; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          alm_en_q[gi]   <= 1'b0;
          alm_time_q[gi] <= '0;
        end else if (alm_wr && alm_idx == IW'(gi)) begin
          alm_en_q[gi]   <= alm_en;
          alm_time_q[gi] <= alm_time;
        end
      end
    end
  endgenerate

  // sec_tick_q doubles as "time just advanced by a tick", so loads never match.
  logic          match;
  logic [IW-1:0] match_idx;
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (alm_en_q[i] && alm_time_q[i] == time_q[23:8]) begin
        match     = 1'b1;
        match_idx = IW'(i);
      end
    end
    match = match & sec_tick_q & (time_q[7:0] == 8'h00);
  end

  state_t        state_q;
  logic          ring_q;
  logic [IW-1:0] ring_idx_q;
  logic [RW-1:0] ring_cnt_q;
  logic [SW-1:0] snz_cnt_q;
  logic          kill;

  assign kill = alm_wr & ~alm_en & (alm_idx == ring_idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ring_q     <= 1'b0;
      ring_idx_q <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (match) begin
            state_q    <= S_RING;
            ring_q     <= 1'b1;
            ring_idx_q <= match_idx;
            ring_cnt_q <= '0;
          end
        end
        S_RING: begin
          if (stop || kill) begin
            state_q <= S_IDLE;
            ring_q  <= 1'b0;
          end else if (snooze) begin
            state_q   <= S_SNOOZE;
            ring_q    <= 1'b0;
            snz_cnt_q <= '0;
          end else if (tick_eff) begin
            if (ring_cnt_q == RW'(RING_SEC - 1)) begin
              state_q <= S_IDLE;
              ring_q  <= 1'b0;
            end else ring_cnt_q <= ring_cnt_q + RW'(1);
          end
        end
        S_SNOOZE: begin
          if (stop || kill) begin
            state_q <= S_IDLE;
          end else if (tick_eff) begin
            if (snz_cnt_q == SW'(SNZ_TICKS - 1)) begin
              state_q    <= S_RING;
              ring_q     <= 1'b1;
              ring_cnt_q <= '0;
            end else snz_cnt_q <= snz_cnt_q + SW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          ring_q  <= 1'b0;
        end
      endcase
    end
  end

  // 12-hour view: 00 -> 12 AM, 12 -> 12 PM, 13..23 -> 1..11 PM.
  logic [4:0] h_bin, h12;
  logic [3:0] h12_shi, h12_ge;
  always_comb begin
    h_bin = 5'(time_q[23:20]) * 5'd10 + 5'(time_q[19:16]);
    if (h_bin == 5'd0)       h12 = 5'd12;
    else if (h_bin > 5'd12)  h12 = h_bin - 5'd12;
    else                     h12 = h_bin;
    h12_shi = (h12 >= 5'd10) ? 4'd1 : 4'd0;
    h12_ge  = (h12 >= 5'd10) ? 4'(h12 - 5'd10) : 4'(h12);
  end

  assign disp_bcd = mode_12h ? {h12_shi, h12_ge, time_q[15:0]} : time_q;
  assign pm       = mode_12h & (h_bin >= 5'd12);
  assign time_bcd = time_q;
  assign sec_tick = sec_tick_q;
  assign set_err  = set_err_q;
  assign ring     = ring_q;
  assign ring_idx = ring_idx_q;

endmodule
